// File: rtl/rosc_meas_ctrl.sv
// Ring-oscillator aging measurement sequencer: stresses the array while idle, then
// settles and counts reference/stressed divided edges of one selected pair over a CLK window.
module rosc_meas_ctrl #(
  parameter int N_PAIRS    = 8,
  parameter int SEL_W      = 3,
  parameter int WIN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [SEL_W-1:0]   SEL,
  input  logic [WIN_W-1:0]   WIN,
  input  logic               STRESS,
  input  logic               REF_DIV,
  input  logic               STR_DIV,
  output logic [N_PAIRS-1:0] REF_EN,
  output logic [N_PAIRS-1:0] STR_EN,
  output logic [SEL_W-1:0]   MUX_SEL,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [CNT_W-1:0]   REF_CNT,
  output logic [CNT_W-1:0]   STR_CNT,
  output logic               OVF
);

  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [ST_W-1:0]    settle_cnt;
  logic [WIN_W-1:0]   win_len;
  logic [WIN_W-1:0]   win_cnt;
  logic               stress_q;
  logic               ref_sync_p0, ref_sync_p1, ref_hist_p2;
  logic               str_sync_p0, str_sync_p1, str_hist_p2;
  logic               ref_rise, str_rise;
  logic               sel_ok, req_ok, accept, reject;
  logic               settle_last, win_last;
  logic [N_PAIRS-1:0] sel_hot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Widened compare so N_PAIRS == 2**SEL_W does not truncate to zero.
  assign sel_ok      = ({1'b0, SEL} < (SEL_W+1)'(N_PAIRS));
  assign req_ok      = sel_ok && (WIN != '0);
  assign accept      = (state == S_IDLE) && START && req_ok;
  assign reject      = (state == S_IDLE) && START && !req_ok;
  assign settle_last = (settle_cnt == ST_W'(SETTLE_CYC - 1));
  assign win_last    = (win_cnt == win_len - WIN_W'(1));
  assign sel_hot     = N_PAIRS'(1) << MUX_SEL;
  assign ref_rise    = ref_sync_p1 && !ref_hist_p2;
  assign str_rise    = str_sync_p1 && !str_hist_p2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    REF_EN    = '0;
    STR_EN    = {N_PAIRS{stress_q}};
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        BUSY   = 1'b1;
        REF_EN = sel_hot;
        STR_EN = sel_hot;
        if (settle_last) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        BUSY   = 1'b1;
        REF_EN = sel_hot;
        STR_EN = sel_hot;
        if (win_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE      = 1'b1;
        REF_EN    = sel_hot;
        STR_EN    = sel_hot;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0/p1: two-flop synchronizers; stage p2: history flop for rise detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ref_sync_p0 <= 1'b0;
      ref_sync_p1 <= 1'b0;
      ref_hist_p2 <= 1'b0;
      str_sync_p0 <= 1'b0;
      str_sync_p1 <= 1'b0;
      str_hist_p2 <= 1'b0;
      stress_q    <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      ref_sync_p0 <= REF_DIV;
      ref_sync_p1 <= ref_sync_p0;
      ref_hist_p2 <= ref_sync_p1;
      str_sync_p0 <= STR_DIV;
      str_sync_p1 <= str_sync_p0;
      str_hist_p2 <= str_sync_p1;
      stress_q    <= STRESS;
      ERR         <= reject;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      MUX_SEL    <= '0;
      win_len    <= '0;
      settle_cnt <= '0;
      win_cnt    <= '0;
    end else if (accept) begin
      MUX_SEL    <= SEL;
      win_len    <= WIN;
      settle_cnt <= '0;
      win_cnt    <= '0;
    end else begin
      if (state == S_SETTLE) settle_cnt <= settle_cnt + ST_W'(1);
      if (state == S_MEASURE) win_cnt <= win_cnt + WIN_W'(1);
    end
  end

  // Counts only advance on edges seen while MEASURE is the current state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      REF_CNT <= '0;
      STR_CNT <= '0;
      OVF     <= 1'b0;
    end else if (accept) begin
      REF_CNT <= '0;
      STR_CNT <= '0;
      OVF     <= 1'b0;
    end else if (state == S_MEASURE) begin
      if (ref_rise) REF_CNT <= sat_inc(REF_CNT);
      if (str_rise) STR_CNT <= sat_inc(STR_CNT);
      if ((ref_rise && (REF_CNT == {CNT_W{1'b1}})) ||
          (str_rise && (STR_CNT == {CNT_W{1'b1}})))
        OVF <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rosc_meas_ctrl.sv
// Directed bench for rosc_meas_ctrl: a 16-bit counter instance and a 4-bit counter
// instance share all stimulus so saturation can be observed alongside exact counts.
module tb_rosc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stress, ref_div, str_div;
  logic [3:0]  sel;
  logic [15:0] win;

  logic [7:0]  ref_en, str_en, ref_en2, str_en2;
  logic [3:0]  mux_sel, mux_sel2;
  logic        busy, d_done, err, ovf;
  logic        busy2, d_done2, err2, ovf2;
  logic [15:0] ref_cnt, str_cnt;
  logic [3:0]  ref_cnt2, str_cnt2;

  int tests = 0;
  int fails = 0;
  int ref_per = 0, str_per = 0;
  int ref_ph = 0, str_ph = 0;

  always #5 clk = ~clk;

  rosc_meas_ctrl #(.N_PAIRS(8), .SEL_W(4), .WIN_W(16), .CNT_W(16), .SETTLE_CYC(64)) dut (
    .CLK(clk), .RST(rst), .START(start), .SEL(sel), .WIN(win), .STRESS(stress),
    .REF_DIV(ref_div), .STR_DIV(str_div), .REF_EN(ref_en), .STR_EN(str_en),
    .MUX_SEL(mux_sel), .BUSY(busy), .DONE(d_done), .ERR(err),
    .REF_CNT(ref_cnt), .STR_CNT(str_cnt), .OVF(ovf)
  );

  rosc_meas_ctrl #(.N_PAIRS(8), .SEL_W(4), .WIN_W(16), .CNT_W(4), .SETTLE_CYC(64)) dut4 (
    .CLK(clk), .RST(rst), .START(start), .SEL(sel), .WIN(win), .STRESS(stress),
    .REF_DIV(ref_div), .STR_DIV(str_div), .REF_EN(ref_en2), .STR_EN(str_en2),
    .MUX_SEL(mux_sel2), .BUSY(busy2), .DONE(d_done2), .ERR(err2),
    .REF_CNT(ref_cnt2), .STR_CNT(str_cnt2), .OVF(ovf2)
  );

  // Divided-oscillator models: square waves with whole-CLK periods, 50% duty.
  always @(negedge clk) begin
    if (ref_per > 0) begin
      ref_ph  = (ref_ph + 1) % ref_per;
      ref_div = (ref_ph < ref_per / 2);
    end else begin
      ref_div = 1'b0;
    end
    if (str_per > 0) begin
      str_ph  = (str_ph + 1) % str_per;
      str_div = (str_ph < str_per / 2);
    end else begin
      str_div = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; stress = 1'b1; start = 1'b0; sel = '0; win = '0;
    repeat (3) tick();
    tests++; if (ref_en !== 8'h00 || str_en !== 8'h00) begin fails++;
      $display("FAIL reset_en: got ref=%h str=%h expected 00/00", ref_en, str_en); end
    tests++; if (busy !== 1'b0 || d_done !== 1'b0 || err !== 1'b0 || ovf !== 1'b0) begin fails++;
      $display("FAIL reset_flags: got busy=%b done=%b err=%b ovf=%b expected 0000", busy, d_done, err, ovf); end
    tests++; if (ref_cnt !== 16'd0 || str_cnt !== 16'd0 || mux_sel !== 4'd0) begin fails++;
      $display("FAIL reset_regs: got ref=%0d str=%0d mux=%0d expected 0/0/0", ref_cnt, str_cnt, mux_sel); end
    rst = 1'b0;
    repeat (5) tick();
    tests++; if (str_en !== 8'hFF || ref_en !== 8'h00) begin fails++;
      $display("FAIL idle_stress: got str=%h ref=%h expected ff/00", str_en, ref_en); end
    stress = 1'b0;
    tick();
    tests++; if (str_en !== 8'h00) begin fails++;
      $display("FAIL stress_off: got str=%h expected 00", str_en); end
  endtask

  task automatic test_measure();
    int done_at = 0, bad_en = 0, bad_busy = 0;
    logic busy_at_done = 1'b1;
    ref_per = 10; str_per = 12; stress = 1'b1;
    repeat (20) tick();
    start = 1'b1; sel = 4'd3; win = 16'd100;
    for (int i = 1; i <= 166; i++) begin
      tick();
      if (i == 1) begin start = 1'b0; sel = 4'd6; win = 16'd3; end
      if (d_done === 1'b1 && done_at == 0) done_at = i;
      if (i <= 165 && (ref_en !== 8'h08 || str_en !== 8'h08)) bad_en++;
      if (i <= 164 && busy !== 1'b1) bad_busy++;
      if (i == 165) busy_at_done = busy;
    end
    tests++; if (done_at != 165) begin fails++;
      $display("FAIL done_latency: got %0d expected 165", done_at); end
    tests++; if (bad_en != 0) begin fails++;
      $display("FAIL enables_onehot: got %0d bad cycles expected 0", bad_en); end
    tests++; if (bad_busy != 0 || busy_at_done !== 1'b0) begin fails++;
      $display("FAIL busy_window: got %0d bad cycles, busy_in_done=%b expected 0/0", bad_busy, busy_at_done); end
    tests++; if (d_done !== 1'b0 || ref_en !== 8'h00 || str_en !== 8'hFF) begin fails++;
      $display("FAIL back_to_idle: got done=%b ref=%h str=%h expected 0/00/ff", d_done, ref_en, str_en); end
    tests++; if (ref_cnt !== 16'd10 || ref_cnt2 !== 4'd10) begin fails++;
      $display("FAIL ref_count: got %0d/%0d expected 10/10", ref_cnt, ref_cnt2); end
    tests++; if (str_cnt < 16'd8 || str_cnt > 16'd9) begin fails++;
      $display("FAIL str_count: got %0d expected 8..9", str_cnt); end
    tests++; if (ovf !== 1'b0 || mux_sel !== 4'd3 || mux_sel2 !== 4'd3) begin fails++;
      $display("FAIL meas_misc: got ovf=%b mux=%0d/%0d expected 0/3/3", ovf, mux_sel, mux_sel2); end
    repeat (30) tick();
    tests++; if (ref_cnt !== 16'd10) begin fails++;
      $display("FAIL count_hold: got %0d expected 10", ref_cnt); end
    stress = 1'b0; ref_per = 0; str_per = 0;
    repeat (4) tick();
  endtask

  task automatic test_reject();
    logic [3:0]  sels [3] = '{4'd9, 4'd2, 4'd8};
    logic [15:0] wins [3] = '{16'd50, 16'd0, 16'd50};
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; sel = sels[k]; win = wins[k];
      tick();
      start = 1'b0;
      tests++; if (err !== 1'b1 || busy !== 1'b0 || err2 !== 1'b1) begin fails++;
        $display("FAIL reject_err%0d: got err=%b busy=%b expected 1/0", k, err, busy); end
      tick();
      tests++; if (err !== 1'b0 || busy !== 1'b0 || ref_cnt !== 16'd10 || mux_sel !== 4'd3) begin fails++;
        $display("FAIL reject_hold%0d: got err=%b busy=%b cnt=%0d mux=%0d expected 0/0/10/3",
                 k, err, busy, ref_cnt, mux_sel); end
    end
  endtask

  task automatic test_saturate();
    int done_at = 0;
    ref_per = 4; str_per = 0;
    repeat (10) tick();
    start = 1'b1; sel = 4'd0; win = 16'd200;
    for (int i = 1; i <= 400 && done_at == 0; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (d_done2 === 1'b1) done_at = i;
    end
    tests++; if (done_at != 265) begin fails++;
      $display("FAIL sat_done: got %0d expected 265", done_at); end
    tests++; if (ref_cnt2 !== 4'd15 || ovf2 !== 1'b1) begin fails++;
      $display("FAIL sat_count: got cnt=%0d ovf=%b expected 15/1", ref_cnt2, ovf2); end
    tests++; if (ref_cnt !== 16'd50 || ovf !== 1'b0 || str_cnt !== 16'd0) begin fails++;
      $display("FAIL wide_count: got ref=%0d ovf=%b str=%0d expected 50/0/0", ref_cnt, ovf, str_cnt); end
    repeat (5) tick();
    tests++; if (ref_cnt2 !== 4'd15 || ovf2 !== 1'b1) begin fails++;
      $display("FAIL sat_hold: got cnt=%0d ovf=%b expected 15/1", ref_cnt2, ovf2); end
    ref_per = 0;
    start = 1'b1; sel = 4'd1; win = 16'd5;
    tick();
    start = 1'b0;
    tests++; if (ovf2 !== 1'b0 || ref_cnt2 !== 4'd0 || busy2 !== 1'b1) begin fails++;
      $display("FAIL ovf_clear: got ovf=%b cnt=%0d busy=%b expected 0/0/1", ovf2, ref_cnt2, busy2); end
    repeat (80) tick();
  endtask

  task automatic test_ignore_start();
    int dones = 0, errs = 0, done_at = 0;
    logic [3:0] mux_mid = '0;
    start = 1'b1; sel = 4'd3; win = 16'd20;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (i == 70) begin start = 1'b1; sel = 4'd5; win = 16'd7; end
      if (i == 71) start = 1'b0;
      if (i == 72) mux_mid = mux_sel;
      if (d_done === 1'b1) begin dones++; if (done_at == 0) done_at = i; end
      if (err === 1'b1) errs++;
    end
    tests++; if (dones != 1 || done_at != 85) begin fails++;
      $display("FAIL ignore_done: got %0d pulses at %0d expected 1 at 85", dones, done_at); end
    tests++; if (errs != 0 || mux_mid !== 4'd3) begin fails++;
      $display("FAIL ignore_sel: got errs=%0d mux=%0d expected 0/3", errs, mux_mid); end
  endtask

  task automatic test_rst_mid();
    int dones = 0;
    ref_per = 10;
    repeat (10) tick();
    start = 1'b1; sel = 4'd6; win = 16'd100;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 1) start = 1'b0;
    end
    tests++; if (ref_cnt == 16'd0 || busy !== 1'b1 || ref_en !== 8'h40) begin fails++;
      $display("FAIL pre_rst: got cnt=%0d busy=%b ref=%h expected >0/1/40", ref_cnt, busy, ref_en); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (ref_en !== 8'h00 || str_en !== 8'h00 || busy !== 1'b0 || d_done !== 1'b0) begin fails++;
      $display("FAIL rst_outputs: got ref=%h str=%h busy=%b done=%b expected 00/00/0/0",
               ref_en, str_en, busy, d_done); end
    tests++; if (ref_cnt !== 16'd0 || str_cnt !== 16'd0 || mux_sel !== 4'd0) begin fails++;
      $display("FAIL rst_counts: got ref=%0d str=%0d mux=%0d expected 0/0/0", ref_cnt, str_cnt, mux_sel); end
    for (int i = 0; i < 200; i++) begin
      tick();
      if (d_done === 1'b1 || busy === 1'b1) dones++;
    end
    tests++; if (dones != 0) begin fails++;
      $display("FAIL rst_no_done: got %0d active cycles expected 0", dones); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stress = 1'b0; sel = '0; win = '0;
    ref_div = 1'b0; str_div = 1'b0;
    test_reset();
    test_measure();
    test_reject();
    test_saturate();
    test_ignore_start();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
